// File: rtl/buffer7x7_scan_ctrl.sv
// Serpentine scan sequencer for a 7x7 window buffer: fills the first window with
// seven column strips, then walks the frame one strip fetch per window step.
module buffer7x7_scan_ctrl #(
  parameter  int IMG_W = 64,
  parameter  int IMG_H = 64,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          fetch_req,
  output logic          fetch_vert,
  output logic [XW-1:0] fetch_x,
  output logic [YW-1:0] fetch_y,
  input  logic          fetch_ack,
  output logic          shift_enable,
  output logic [1:0]    shift_dir,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          win_last,
  output logic          done
);

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 7);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 7);
  localparam logic [XW-1:0] X_SEVEN = XW'(7);
  localparam logic [YW-1:0] Y_SEVEN = YW'(7);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PRESENT,
    S_MOVE,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      fill_cnt, fill_cnt_nxt;
  logic [XW-1:0]   wx, wx_nxt;
  logic [YW-1:0]   wy, wy_nxt;
  logic            dir_fwd, dir_fwd_nxt;
  logic            row_end;
  logic            last_win;

  // Row end depends on travel direction: right edge going forward, left edge coming back.
  assign row_end  = dir_fwd ? (wx == X_LAST) : (wx == '0);
  assign last_win = row_end && (wy == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
      wx       <= '0;
      wy       <= '0;
      dir_fwd  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      wx       <= wx_nxt;
      wy       <= wy_nxt;
      dir_fwd  <= dir_fwd_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    wx_nxt       = wx;
    wy_nxt       = wy;
    dir_fwd_nxt  = dir_fwd;
    busy         = 1'b0;
    fetch_req    = 1'b0;
    fetch_vert   = 1'b0;
    fetch_x      = '0;
    fetch_y      = '0;
    shift_dir    = 2'b00;
    win_valid    = 1'b0;
    win_last     = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_FILL;
          fill_cnt_nxt = '0;
          wx_nxt       = '0;
          wy_nxt       = '0;
          dir_fwd_nxt  = 1'b1;
        end
      end
      S_FILL: begin
        busy       = 1'b1;
        fetch_req  = 1'b1;
        fetch_vert = 1'b1;
        fetch_x    = XW'(fill_cnt);
        shift_dir  = 2'b01;
        if (fetch_ack) begin
          fill_cnt_nxt = fill_cnt + 3'd1;
          if (fill_cnt == 3'd6) state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        win_last  = last_win;
        if (win_ready) state_nxt = last_win ? S_DONE : S_MOVE;
      end
      S_MOVE: begin
        busy      = 1'b1;
        fetch_req = 1'b1;
        if (row_end) begin
          fetch_vert = 1'b0;
          fetch_x    = wx;
          fetch_y    = wy + Y_SEVEN;
          shift_dir  = 2'b11;
          if (fetch_ack) begin
            wy_nxt      = wy + Y_ONE;
            dir_fwd_nxt = ~dir_fwd;
          end
        end else if (dir_fwd) begin
          fetch_vert = 1'b1;
          fetch_x    = wx + X_SEVEN;
          fetch_y    = wy;
          shift_dir  = 2'b01;
          if (fetch_ack) wx_nxt = wx + X_ONE;
        end else begin
          fetch_vert = 1'b1;
          fetch_x    = wx - X_ONE;
          fetch_y    = wy;
          shift_dir  = 2'b10;
          if (fetch_ack) wx_nxt = wx - X_ONE;
        end
        if (fetch_ack) state_nxt = S_PRESENT;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign shift_enable = fetch_req & fetch_ack;
  assign win_x        = wx;
  assign win_y        = wy;

endmodule

// File: tb/tb_buffer7x7_scan_ctrl.sv
// Scoreboard bench: four scan controllers (8x8, 7x7, 7x9, 64x64) checked against a
// serpentine window/fetch model built from the frame geometry.
module tb_buffer7x7_scan_ctrl;

  localparam int NI = 4;

  function automatic int img_w(input int g);
    case (g)
      0:       return 8;
      1, 2:    return 7;
      default: return 64;
    endcase
  endfunction

  function automatic int img_h(input int g);
    case (g)
      0:       return 8;
      1:       return 7;
      2:       return 9;
      default: return 64;
    endcase
  endfunction

  typedef struct {int x; int y; bit last;} win_t;
  typedef struct {int x; int y; bit vert; int dir;} fet_t;

  win_t exp_win[NI][$];
  fet_t exp_fetch[NI][$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] start_v = '0;
  logic [NI-1:0] ack_v = '1;
  logic [NI-1:0] rdy_v = '1;
  logic [NI-1:0] idle_v, freq_v, acc_v;
  int            ack_pct[NI] = '{100, 100, 100, 100};
  int            rdy_pct[NI] = '{100, 100, 100, 100};
  int            done_cnt[NI] = '{0, 0, 0, 0};
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: list windows in serpentine order, derive the strip each step needs.
  task automatic build(input int g);
    int w, h, n;
    win_t wl[$];
    win_t a, b;
    w = img_w(g);
    h = img_h(g);
    exp_win[g].delete();
    exp_fetch[g].delete();
    for (int c = 0; c < 7; c++) exp_fetch[g].push_back('{c, 0, 1'b1, 1});
    for (int r = 0; r <= h - 7; r++)
      for (int k = 0; k <= w - 7; k++)
        wl.push_back('{((r % 2) == 0) ? k : (w - 7 - k), r, (r == h - 7) && (k == w - 7)});
    n = wl.size();
    for (int i = 1; i < n; i++) begin
      a = wl[i-1];
      b = wl[i];
      if (b.y != a.y)     exp_fetch[g].push_back('{a.x, a.y + 7, 1'b0, 3});
      else if (b.x > a.x) exp_fetch[g].push_back('{a.x + 7, a.y, 1'b1, 1});
      else                exp_fetch[g].push_back('{a.x - 1, a.y, 1'b1, 2});
    end
    for (int i = 0; i < n; i++) exp_win[g].push_back(wl[i]);
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int W  = img_w(g);
    localparam int H  = img_h(g);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          busy, fetch_req, fetch_vert, shift_enable, win_valid, win_last, done;
    logic [XW-1:0] fetch_x, win_x;
    logic [YW-1:0] fetch_y, win_y;
    logic [1:0]    shift_dir;

    buffer7x7_scan_ctrl #(.IMG_W(W), .IMG_H(H)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_v[g]),
      .busy        (busy),
      .fetch_req   (fetch_req),
      .fetch_vert  (fetch_vert),
      .fetch_x     (fetch_x),
      .fetch_y     (fetch_y),
      .fetch_ack   (ack_v[g]),
      .shift_enable(shift_enable),
      .shift_dir   (shift_dir),
      .win_valid   (win_valid),
      .win_ready   (rdy_v[g]),
      .win_x       (win_x),
      .win_y       (win_y),
      .win_last    (win_last),
      .done        (done)
    );

    assign idle_v[g] = ~|{busy, fetch_req, fetch_vert, fetch_x, fetch_y, shift_enable,
                          shift_dir, win_valid, win_x, win_y, win_last, done};
    assign freq_v[g] = fetch_req;
    assign acc_v[g]  = win_valid & rdy_v[g];

    bit p_fstall = 0, p_wstall = 0, p_last = 0, p_v = 0;
    int p_fx = 0, p_fy = 0, p_dir = 0, p_wx = 0, p_wy = 0;

    always @(negedge clk) begin
      fet_t f;
      win_t e;
      if (rst) begin
        p_fstall = 0;
        p_wstall = 0;
        p_last   = 0;
      end else begin
        chk(shift_enable == (fetch_req & ack_v[g]), $sformatf("i%0d shift_enable", g),
            int'(shift_enable), int'(fetch_req & ack_v[g]));
        if (!fetch_req) chk(shift_dir == 2'b00, $sformatf("i%0d idle shift_dir", g), int'(shift_dir), 0);
        chk(!(fetch_req && win_valid), $sformatf("i%0d fetch+valid overlap", g), int'(fetch_req), 0);
        if (p_fstall)
          chk(fetch_req && int'(fetch_x) == p_fx && int'(fetch_y) == p_fy && int'(shift_dir) == p_dir &&
              fetch_vert == p_v && int'(win_x) == p_wx && int'(win_y) == p_wy,
              $sformatf("i%0d fetch stall hold", g), int'(fetch_x), p_fx);
        if (p_wstall)
          chk(win_valid && !fetch_req && int'(win_x) == p_wx && int'(win_y) == p_wy,
              $sformatf("i%0d window stall hold", g), int'(win_x), p_wx);
        if (shift_enable) begin
          if (exp_fetch[g].size() == 0) chk(0, $sformatf("i%0d unexpected fetch", g), int'(fetch_x), -1);
          else begin
            f = exp_fetch[g].pop_front();
            chk(int'(fetch_x) == f.x, $sformatf("i%0d fetch_x", g), int'(fetch_x), f.x);
            chk(int'(fetch_y) == f.y, $sformatf("i%0d fetch_y", g), int'(fetch_y), f.y);
            chk(fetch_vert == f.vert, $sformatf("i%0d fetch_vert", g), int'(fetch_vert), int'(f.vert));
            chk(int'(shift_dir) == f.dir, $sformatf("i%0d shift_dir", g), int'(shift_dir), f.dir);
          end
        end
        if (win_valid && rdy_v[g]) begin
          chk(busy, $sformatf("i%0d busy in window", g), int'(busy), 1);
          if (exp_win[g].size() == 0) chk(0, $sformatf("i%0d unexpected window", g), int'(win_x), -1);
          else begin
            e = exp_win[g].pop_front();
            chk(int'(win_x) == e.x, $sformatf("i%0d win_x", g), int'(win_x), e.x);
            chk(int'(win_y) == e.y, $sformatf("i%0d win_y", g), int'(win_y), e.y);
            chk(win_last == e.last, $sformatf("i%0d win_last", g), int'(win_last), int'(e.last));
          end
        end
        if (done || p_last) begin
          chk(done == p_last, $sformatf("i%0d done after last", g), int'(done), int'(p_last));
          if (done) begin
            done_cnt[g]++;
            chk(!busy, $sformatf("i%0d busy at done", g), int'(busy), 0);
            chk(exp_win[g].size() == 0, $sformatf("i%0d windows left at done", g), exp_win[g].size(), 0);
          end
        end
        p_fstall = fetch_req & ~ack_v[g];
        p_wstall = win_valid & ~rdy_v[g];
        p_last   = win_valid & rdy_v[g] & win_last;
        p_fx     = int'(fetch_x);
        p_fy     = int'(fetch_y);
        p_dir    = int'(shift_dir);
        p_v      = fetch_vert;
        p_wx     = int'(win_x);
        p_wy     = int'(win_y);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        ack_v[g] = ($urandom_range(0, 99) < ack_pct[g]);
        rdy_v[g] = ($urandom_range(0, 99) < rdy_pct[g]);
      end
    end
  end

  task automatic pulse_start(input logic [NI-1:0] m);
    @(posedge clk);
    #1 start_v = m;
    @(posedge clk);
    #1 start_v = '0;
  endtask

  task automatic wait_done(input int g, input int target, input int budget);
    int n = 0;
    while (done_cnt[g] < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(done_cnt[g] == target, $sformatf("i%0d done count", g), done_cnt[g], target);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) chk(idle_v[g], $sformatf("i%0d reset outputs", g), int'(idle_v[g]), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // All frames at once; a second start during the fill must be ignored.
    for (int g = 0; g < NI; g++) build(g);
    ack_pct[2] = 60; rdy_pct[2] = 50;
    ack_pct[3] = 60; rdy_pct[3] = 70;
    pulse_start('1);
    repeat (4) @(posedge clk);
    #1 start_v = '1;
    @(posedge clk);
    #1 start_v = '0;
    for (int g = 0; g < NI; g++) wait_done(g, 1, 40000);
    for (int g = 0; g < NI; g++)
      chk(exp_fetch[g].size() == 0, $sformatf("i%0d fetches left", g), exp_fetch[g].size(), 0);

    // 8x8 again with heavy back-pressure on both handshakes.
    ack_pct[0] = 40; rdy_pct[0] = 40;
    build(0);
    pulse_start(4'b0001);
    wait_done(0, 2, 3000);

    // Abort during a stalled move, then rescan from scratch.
    ack_pct[0] = 100; rdy_pct[0] = 100;
    build(0);
    pulse_start(4'b0001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!acc_v[0] && n < 100);
    chk(acc_v[0], "first window before abort", int'(acc_v[0]), 1);
    ack_pct[0] = 0;
    repeat (4) @(negedge clk);
    chk(freq_v[0], "move stalled before abort", int'(freq_v[0]), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) chk(idle_v[g], $sformatf("i%0d outputs after abort", g), int'(idle_v[g]), 1);
    repeat (3) @(negedge clk);
    chk(done_cnt[0] == 2, "no done on abort", done_cnt[0], 2);
    @(posedge clk);
    #1 rst = 1'b0;
    ack_pct[0] = 100;
    build(0);
    pulse_start(4'b0001);
    wait_done(0, 3, 500);
    chk(exp_fetch[0].size() == 0, "i0 fetches left after rescan", exp_fetch[0].size(), 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
